alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU feeding the accumulator.
// Combines the accumulator value (a) with a second operand (b) and
// presents a registered result. Single-cycle ops (ADD, SUB, AND, OR,
// XOR, SHL, SHR) go IDLE -> DONE; MUL runs an iterative shift-add for
// SIZE cycles before DONE. done is a one-cycle pulse used as the
// accumulator write enable.
//
// Ports:
//   clk     in   rising-edge clock
//   rstn    in   asynchronous active-low reset
//   start   in   request, sampled only in IDLE
//   op      in   [2:0] operation select, captured with start
//   a, b    in   [SIZE-1:0] operands, captured with start
//   busy    out  state != IDLE
//   done    out  one-cycle result-valid pulse
//   result  out  [SIZE-1:0] registered result, held until next done
//   carry   out  carry/borrow/overflow flag
//   zero    out  result == 0
module alu_seq #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] result,
  output logic            carry,
  output logic            zero
);

  localparam int CNT_W = (SIZE > 2) ? $clog2(SIZE) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SIZE-1:0]     mcand_q, mcand_d;
  logic [SIZE-1:0]     mplier_q, mplier_d;
  logic [2*SIZE-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SIZE-1:0]     result_q, result_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;

  logic [SIZE:0]       sum_w, diff_w;
  logic [SIZE-1:0]     alu_res;
  logic                alu_c;
  logic [SIZE:0]       acc_w;
  logic [2*SIZE-1:0]   prod_step;

  // Single-cycle datapath; unsigned arithmetic with one extra bit so the
  // top bit is the carry (ADD) or borrow (SUB).
  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    diff_w  = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum_w[SIZE-1:0];  alu_c = sum_w[SIZE];  end
      OP_SUB: begin alu_res = diff_w[SIZE-1:0]; alu_c = diff_w[SIZE]; end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin alu_res = {a[SIZE-2:0], 1'b0}; alu_c = a[SIZE-1]; end
      OP_SHR: begin alu_res = {1'b0, a[SIZE-1:1]}; alu_c = a[0];      end
      default: begin alu_res = '0; alu_c = 1'b0; end
    endcase
  end

  // One shift-add iteration: conditionally add the multiplicand into the
  // upper half (keeping its carry-out), then shift the whole product right.
  always_comb begin
    acc_w     = {1'b0, prod_q[2*SIZE-1:SIZE]} +
                (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {acc_w, prod_q[SIZE-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            carry_d  = alu_c;
            zero_d   = (alu_res == '0);
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last iteration: publish the finished product on the same edge.
        if (cnt_q == CNT_W'(SIZE - 1)) begin
          result_d = prod_step[SIZE-1:0];
          carry_d  = |prod_step[2*SIZE-1:SIZE];
          zero_d   = (prod_step[SIZE-1:0] == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int SIZE = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [2:0]      op;
  logic [SIZE-1:0] a, b;
  logic            busy, done, carry, zero;
  logic [SIZE-1:0] result;

  alu_seq #(.SIZE(SIZE)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SIZE-1:0] res;
    logic            c;
    logic            z;
  } exp_t;

  typedef struct {
    logic [2:0]      op;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] res;
    logic            c;
    logic            z;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each done pulse pops one expected record.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      chk("done_implies_busy", {31'd0, busy}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {24'd0, result}, {24'd0, e.res});
        chk("carry",  {31'd0, carry},  {31'd0, e.c});
        chk("zero",   {31'd0, zero},   {31'd0, e.z});
      end
    end
  end

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 50) begin tick(); cyc++; end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one op, check latency, busy and the single done pulse.
  task automatic run_op(input logic [2:0] o, input logic [SIZE-1:0] x,
                        input logic [SIZE-1:0] y, input logic [SIZE-1:0] res,
                        input logic c, input logic z);
    int cyc;
    int d0;
    wait_idle();
    @(negedge clk);
    d0    = done_cnt;
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back('{res: res, c: c, z: z});
    tick();
    start = 1'b0;
    op = 3'($urandom); a = SIZE'($urandom); b = SIZE'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    if (o != OP_MUL) begin
      chk("done_latency_1cyc", {31'd0, done}, 32'd1);
    end else begin
      cyc = 0;
      while (!done && cyc < 50) begin tick(); cyc++; end
      chk("mul_latency", cyc, SIZE);
    end
    tick();
    chk("done_width", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("done_count", done_cnt - d0, 32'd1);
  endtask

  initial begin
    vec_t vecs[14];
    int   d0;
    logic [SIZE-1:0] last_res;

    vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{OP_SUB, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[4]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
    vecs[5]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{OP_SHL, 8'h81, 8'h55, 8'h02, 1'b1, 1'b0};
    vecs[7]  = '{OP_SHR, 8'h81, 8'h55, 8'h40, 1'b1, 1'b0};
    vecs[8]  = '{OP_SHR, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{OP_MUL, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[13] = '{OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};

    rstn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) tick();
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_carry",  {31'd0, carry},  32'd0);
    chk("rst_zero",   {31'd0, zero},   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].z);

    // Result holds while idle.
    last_res = result;
    repeat (4) tick();
    chk("result_hold", {24'd0, result}, 32'h46);
    chk("result_hold_stable", {24'd0, result}, {24'd0, last_res});

    // start during MUL must be ignored and must not disturb captured operands.
    wait_idle();
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; op = OP_MUL; a = 8'd3; b = 8'd4;
    exp_q.push_back('{res: 8'h0C, c: 1'b0, z: 1'b0});
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
    tick();
    start = 1'b0; a = 8'hEE; b = 8'h77;
    wait_idle();
    repeat (4) tick();
    chk("mul_ignore_done_count", done_cnt - d0, 32'd1);
    chk("mul_ignore_result", {24'd0, result}, 32'h0C);

    // Reset in the middle of a MUL aborts it with no done pulse.
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; op = OP_MUL; a = 8'h0F; b = 8'h11;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_mul_busy", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("abort_busy",   {31'd0, busy},   32'd0);
    chk("abort_done",   {31'd0, done},   32'd0);
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_carry",  {31'd0, carry},  32'd0);
    chk("abort_zero",   {31'd0, zero},   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (12) tick();
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);

    run_op(OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
